// File: rtl/playbus_ctrl.sv
// Play-bus transfer controller: arbitrates two requesters round-robin, drives
// one bus source for SETUP cycles, strobes the destination, then acknowledges.
// Illegal source/destination pairs are rejected with a one-cycle err pulse.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request; arbitration and select latch here
// DRIVE  | source enable on, counting down SETUP cycles
// STROBE | source enable on, destination strobe on for one cycle
// HOLD   | source enable on after the strobe, one cycle
// DONE   | ack pulse to the granted requester
// ERR    | ack + err pulse for a rejected transfer
module playbus_ctrl #(
    parameter int unsigned SETUP = 1
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    input  logic [1:0] src0_i,
    input  logic [1:0] src1_i,
    input  logic       dst0_i,
    input  logic       dst1_i,
    output logic [1:0] ack_o,
    output logic       err_o,
    output logic       busy_o,
    output logic       romo_o,
    output logic       ramo_o,
    output logic       swben_o,
    output logic       ramw_o,
    output logic       ledltch_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam logic [1:0] SRC_ROM    = 2'b00;
    localparam logic [1:0] SRC_RAM    = 2'b01;
    localparam logic [1:0] SRC_SW     = 2'b10;
    localparam logic [1:0] SRC_RSVD   = 2'b11;
    localparam logic       DST_RAM    = 1'b0;
    localparam logic [3:0] SETUP_LOAD = 4'(SETUP - 1);

    state_t     state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_grant_q, last_grant_d;
    logic [1:0] src_q, src_d;
    logic       dst_q, dst_d;
    logic [3:0] cnt_q, cnt_d;
    logic       gnt;
    logic       src_en;

    logic [1:0] ack_d;
    logic       err_d, busy_d, romo_d, ramo_d, swben_d, ramw_d, ledltch_d;

    // Next state, arbitration, select latch, and output values for the next cycle.
    // Outputs are decoded from the next state so they leave the block registered.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        src_d        = src_q;
        dst_d        = dst_q;
        cnt_d        = cnt_q;
        gnt          = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    // A tie goes to whoever was not served last.
                    gnt          = (req_i == 2'b11) ? ~last_grant_q : req_i[1];
                    grant_d      = gnt;
                    last_grant_d = gnt;
                    src_d        = gnt ? src1_i : src0_i;
                    dst_d        = gnt ? dst1_i : dst0_i;
                    if (src_d == SRC_RSVD || (src_d == SRC_RAM && dst_d == DST_RAM)) begin
                        state_d = ERR;
                    end else begin
                        state_d = DRIVE;
                        cnt_d   = SETUP_LOAD;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == 4'd0) begin
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE:  state_d = HOLD;
            HOLD:    state_d = DONE;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        src_en    = (state_d == DRIVE) || (state_d == STROBE) || (state_d == HOLD);
        ack_d     = 2'b00;
        if (state_d == DONE || state_d == ERR) begin
            ack_d[grant_d] = 1'b1;
        end
        err_d     = (state_d == ERR);
        busy_d    = (state_d != IDLE);
        romo_d    = src_en && (src_d == SRC_ROM);
        ramo_d    = src_en && (src_d == SRC_RAM);
        swben_d   = src_en && (src_d == SRC_SW);
        ramw_d    = (state_d == STROBE) && (dst_d == DST_RAM);
        ledltch_d = (state_d == STROBE) && (dst_d != DST_RAM);
    end

    // State, latched selects, counter and output registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            src_q        <= 2'b00;
            dst_q        <= 1'b0;
            cnt_q        <= 4'd0;
            ack_o        <= 2'b00;
            err_o        <= 1'b0;
            busy_o       <= 1'b0;
            romo_o       <= 1'b0;
            ramo_o       <= 1'b0;
            swben_o      <= 1'b0;
            ramw_o       <= 1'b0;
            ledltch_o    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            cnt_q        <= cnt_d;
            ack_o        <= ack_d;
            err_o        <= err_d;
            busy_o       <= busy_d;
            romo_o       <= romo_d;
            ramo_o       <= ramo_d;
            swben_o      <= swben_d;
            ramw_o       <= ramw_d;
            ledltch_o    <= ledltch_d;
        end
    end

endmodule

// File: tb/tb_playbus_ctrl.sv
// Bench for playbus_ctrl: two instances (SETUP=1 and SETUP=3), directed
// scenarios plus randomized requesters checked against a transfer-schedule model.
module tb_playbus_ctrl;

    localparam int SETUP_A = 1;
    localparam int SETUP_B = 3;

    logic       clk;
    logic       rst;
    logic [1:0] req   [2];
    logic [1:0] src0  [2];
    logic [1:0] src1  [2];
    logic       dst0  [2];
    logic       dst1  [2];
    logic [1:0] ack   [2];
    logic       err   [2];
    logic       busy  [2];
    logic       romo  [2];
    logic       ramo  [2];
    logic       swben [2];
    logic       ramw  [2];
    logic       ledltch [2];

    int total = 0;
    int bad   = 0;

    // Model state: cycle index within the current transfer (0 = idle).
    int         m_k    [2];
    int         m_len  [2];
    logic       m_g    [2];
    logic       m_last [2];
    logic       m_rej  [2];
    logic [1:0] m_src  [2];
    logic       m_dst  [2];

    playbus_ctrl #(.SETUP(SETUP_A)) u_dut_a (
        .clock_i(clk), .reset_i(rst), .req_i(req[0]),
        .src0_i(src0[0]), .src1_i(src1[0]), .dst0_i(dst0[0]), .dst1_i(dst1[0]),
        .ack_o(ack[0]), .err_o(err[0]), .busy_o(busy[0]),
        .romo_o(romo[0]), .ramo_o(ramo[0]), .swben_o(swben[0]),
        .ramw_o(ramw[0]), .ledltch_o(ledltch[0])
    );

    playbus_ctrl #(.SETUP(SETUP_B)) u_dut_b (
        .clock_i(clk), .reset_i(rst), .req_i(req[1]),
        .src0_i(src0[1]), .src1_i(src1[1]), .dst0_i(dst0[1]), .dst1_i(dst1[1]),
        .ack_o(ack[1]), .err_o(err[1]), .busy_o(busy[1]),
        .romo_o(romo[1]), .ramo_o(ramo[1]), .swben_o(swben[1]),
        .ramw_o(ramw[1]), .ledltch_o(ledltch[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle structural properties on both instances.
    for (genvar g = 0; g < 2; g++) begin : g_prop
        a_src_onehot: assert property (@(negedge clk) $onehot0({romo[g], ramo[g], swben[g]}))
            else $error("FAIL src_onehot dut%0d got %b%b%b", g, romo[g], ramo[g], swben[g]);
        a_dst_onehot: assert property (@(negedge clk) $onehot0({ramw[g], ledltch[g]}))
            else $error("FAIL dst_onehot dut%0d got %b%b", g, ramw[g], ledltch[g]);
        a_strobe_src: assert property (@(negedge clk)
            !(ramw[g] || ledltch[g]) || (romo[g] || ramo[g] || swben[g]))
            else $error("FAIL strobe_without_source dut%0d", g);
    end

    // Transfer-level model: a granted transfer is a fixed schedule of cycles 1..len.
    always @(posedge clk) begin
        logic       g;
        logic [1:0] s;
        logic       t;
        logic       rj;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_k[d]    <= 0;
                m_last[d] <= 1'b1;
            end else if (m_k[d] != 0) begin
                m_k[d] <= (m_k[d] == m_len[d]) ? 0 : m_k[d] + 1;
            end else if (req[d] != 2'b00) begin
                g  = (req[d] == 2'b11) ? ~m_last[d] : req[d][1];
                s  = g ? src1[d] : src0[d];
                t  = g ? dst1[d] : dst0[d];
                rj = (s == 2'b11) || (s == 2'b01 && t == 1'b0);
                m_g[d]    <= g;
                m_last[d] <= g;
                m_src[d]  <= s;
                m_dst[d]  <= t;
                m_rej[d]  <= rj;
                m_len[d]  <= rj ? 1 : ((d == 0) ? SETUP_A : SETUP_B) + 3;
                m_k[d]    <= 1;
            end
        end
    end

    // Bit layout: [8:7] ack, [6] err, [5] busy, [4] romo, [3] ramo, [2] swben, [1] ramw, [0] ledltch
    function automatic logic [8:0] obs_of(int d);
        return {ack[d], err[d], busy[d], romo[d], ramo[d], swben[d], ramw[d], ledltch[d]};
    endfunction

    function automatic logic [8:0] exp_out(int d);
        logic [8:0] e;
        int sv;
        int k;
        e  = '0;
        sv = (d == 0) ? SETUP_A : SETUP_B;
        k  = m_k[d];
        if (k != 0) begin
            e[5] = 1'b1;
            if (m_rej[d]) begin
                e[6] = 1'b1;
                if (m_g[d]) e[8] = 1'b1; else e[7] = 1'b1;
            end else begin
                if (k <= sv + 2) begin
                    case (m_src[d])
                        2'b00:   e[4] = 1'b1;
                        2'b01:   e[3] = 1'b1;
                        2'b10:   e[2] = 1'b1;
                        default: ;
                    endcase
                end
                if (k == sv + 1) begin
                    if (m_dst[d]) e[0] = 1'b1; else e[1] = 1'b1;
                end
                if (k == sv + 3) begin
                    if (m_g[d]) e[8] = 1'b1; else e[7] = 1'b1;
                end
            end
        end
        return e;
    endfunction

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            req[d] = 2'b00; src0[d] = 2'b00; src1[d] = 2'b00; dst0[d] = 1'b0; dst1[d] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 2'b11; src0[d] = 2'b00; src1[d] = 2'b10; dst0[d] = 1'b1; dst1[d] = 1'b0;
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_of(d) !== 9'd0) begin
                    bad++;
                    $display("FAIL reset_outputs dut%0d cyc%0d got %b want %b", d, i, obs_of(d), 9'd0);
                end
            end
        end
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (obs_of(d) !== 9'd0) begin
                bad++;
                $display("FAIL post_reset_idle dut%0d got %b want %b", d, obs_of(d), 9'd0);
            end
        end
    endtask

    task automatic test_setup1_sw_to_led();
        logic [8:0] e;
        @(negedge clk);
        req[0] = 2'b01; src0[0] = 2'b10; dst0[0] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            e    = '0;
            e[7] = (i == 4);
            e[5] = (i <= 4);
            e[2] = (i <= 3);
            e[0] = (i == 2);
            total++;
            if (obs_of(0) !== e) begin
                bad++;
                $display("FAIL setup1_sw_led cyc%0d got %b want %b", i, obs_of(0), e);
            end
            if (i == 4) req[0] = 2'b00;
        end
    endtask

    task automatic test_setup3_rom_to_ram();
        logic [8:0] e;
        @(negedge clk);
        req[1] = 2'b10; src1[1] = 2'b00; dst1[1] = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            e    = '0;
            e[8] = (i == 6);
            e[5] = (i <= 6);
            e[4] = (i <= 5);
            e[1] = (i == 4);
            total++;
            if (obs_of(1) !== e) begin
                bad++;
                $display("FAIL setup3_rom_ram cyc%0d got %b want %b", i, obs_of(1), e);
            end
            if (i == 6) req[1] = 2'b00;
        end
    endtask

    task automatic test_reject();
        logic [8:0] e0;
        logic [8:0] e1;
        @(negedge clk);
        req[0] = 2'b01; src0[0] = 2'b01; dst0[0] = 1'b0;
        req[1] = 2'b10; src1[1] = 2'b11; dst1[1] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            e0 = (i == 1) ? 9'b01_1_1_00000 : 9'd0;
            e1 = (i == 1) ? 9'b10_1_1_00000 : 9'd0;
            total++;
            if (obs_of(0) !== e0) begin
                bad++;
                $display("FAIL reject_ram_ram cyc%0d got %b want %b", i, obs_of(0), e0);
            end
            total++;
            if (obs_of(1) !== e1) begin
                bad++;
                $display("FAIL reject_reserved cyc%0d got %b want %b", i, obs_of(1), e1);
            end
            if (i == 1) begin
                req[0] = 2'b00;
                req[1] = 2'b00;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] e;
        int pos;
        int g;
        do_reset();
        @(negedge clk);
        req[0] = 2'b11; src0[0] = 2'b00; dst0[0] = 1'b1; src1[0] = 2'b10; dst1[0] = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            pos = (i - 1) % 5 + 1;
            g   = ((i - 1) / 5) % 2;
            e   = '0;
            if (i <= 15) begin
                e[5] = (pos <= 4);
                if (pos <= 3) begin
                    if (g == 0) e[4] = 1'b1; else e[2] = 1'b1;
                end
                if (pos == 2) begin
                    if (g == 0) e[0] = 1'b1; else e[1] = 1'b1;
                end
                if (pos == 4) begin
                    if (g == 0) e[7] = 1'b1; else e[8] = 1'b1;
                end
            end
            total++;
            if (obs_of(0) !== e) begin
                bad++;
                $display("FAIL back_to_back cyc%0d got %b want %b", i, obs_of(0), e);
            end
            if (i == 15) req[0] = 2'b00;
        end
    endtask

    task automatic test_reset_mid_transfer();
        logic [8:0] e;
        @(negedge clk);
        req[0] = 2'b01; src0[0] = 2'b10; dst0[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (obs_of(0) !== 9'b00_0_1_00101) begin
            bad++;
            $display("FAIL mid_reset_strobe got %b want %b", obs_of(0), 9'b00_0_1_00101);
        end
        rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (obs_of(d) !== 9'd0) begin
                bad++;
                $display("FAIL mid_reset_abort dut%0d got %b want %b", d, obs_of(d), 9'd0);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            e    = '0;
            e[7] = (i == 4);
            e[5] = (i <= 4);
            e[2] = (i <= 3);
            e[0] = (i == 2);
            total++;
            if (obs_of(0) !== e) begin
                bad++;
                $display("FAIL after_reset_regrant cyc%0d got %b want %b", i, obs_of(0), e);
            end
            if (i == 4) req[0] = 2'b00;
        end
    endtask

    task automatic test_random();
        logic [8:0] e;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                e = exp_out(d);
                total++;
                if (obs_of(d) !== e) begin
                    bad++;
                    $display("FAIL random dut%0d cyc%0d got %b want %b", d, c, obs_of(d), e);
                end
            end
            for (int d = 0; d < 2; d++) begin
                for (int r = 0; r < 2; r++) begin
                    if (req[d][r]) begin
                        if (ack[d][r]) req[d][r] = 1'b0;
                    end else if ($urandom_range(0, 2) == 0) begin
                        if (r == 0) begin
                            src0[d] = 2'($urandom_range(0, 3));
                            dst0[d] = 1'($urandom_range(0, 1));
                        end else begin
                            src1[d] = 2'($urandom_range(0, 3));
                            dst1[d] = 1'($urandom_range(0, 1));
                        end
                        req[d][r] = 1'b1;
                    end
                end
            end
        end
        clear_inputs();
        repeat (10) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_setup1_sw_to_led();
        test_setup3_rom_to_ram();
        test_reject();
        test_back_to_back();
        test_reset_mid_transfer();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
